// File: rtl/usb_tx_encoder_if.sv
// Handshake bundle between the protocol controller / data_buffer side and the
// full-speed USB transmit encoder. The master side issues requests and supplies
// payload bytes. The slave side is the encoder, which reports fetch/busy/fault.
interface usb_tx_encoder_if;
  logic       tx_start;
  logic [2:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       get_tx_packet_data;
  logic       tx_transfer_active;
  logic       tx_error;

  modport master (
    output tx_start, tx_packet, buffer_occupancy, tx_packet_data,
    input  get_tx_packet_data, tx_transfer_active, tx_error
  );

  modport slave (
    input  tx_start, tx_packet, buffer_occupancy, tx_packet_data,
    output get_tx_packet_data, tx_transfer_active, tx_error
  );
endinterface

// File: rtl/usb_tx_encoder.sv
// Full-speed USB transmitter. On an accepted request it sends the following
// fields, bit-stuffed and NRZI-encoded onto dplus_out/dminus_out:
//   SYNC, PID, payload (fetched byte-by-byte from data_buffer), CRC16, EOP.
// Optional feature macro: USB_TX_UNDERRUN_CHECK_EN. When it is defined, the
// encoder aborts a data packet if data_buffer is empty when a payload byte
// is due to be fetched.
module usb_tx_encoder #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned MAX_PAYLOAD  = 64
) (
  input  logic            clk,
  input  logic            n_rst,
  usb_tx_encoder_if.slave bus,
  output logic            dplus_out,
  output logic            dminus_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_PAYLOAD,
    S_CRC_LO,
    S_CRC_HI,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  localparam int unsigned   TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMR_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'h80;

  state_t        state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    pid_byte, pid_byte_n;
  logic [7:0]    nxt, nxt_n;
  logic [15:0]   crc, crc_n;
  logic [6:0]    bytes_left, bytes_left_n;
  logic [2:0]    ones, ones_n;
  logic          stuffing, stuffing_n;
  logic          line_k, line_k_n;
  logic          se0_cnt, se0_cnt_n;
  logic          is_data, is_data_n;
  logic          have_next, have_next_n;
  logic          abort, abort_n;
  logic          get_q, get_n, get_d;
  logic          err_q, err_n;

  logic          emit_en, emit_bit;
  logic          load_en;
  logic [7:0]    load_byte;
  logic          fetch_req;

  logic [3:0]    req_pid;
  logic          req_ok, req_data;

  // Reflected CRC16 (poly 0x8005 as 0xA001), one byte processed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Decode the requested packet type and decide whether it can be accepted.
  always_comb begin
    req_pid  = '0;
    req_ok   = 1'b0;
    req_data = 1'b0;
    unique case (bus.tx_packet)
      3'd1: begin req_pid = 4'b0011; req_ok = 1'b1; req_data = 1'b1; end
      3'd2: begin req_pid = 4'b1011; req_ok = 1'b1; req_data = 1'b1; end
      3'd3: begin req_pid = 4'b0010; req_ok = 1'b1; end
      3'd4: begin req_pid = 4'b1010; req_ok = 1'b1; end
      3'd5: begin req_pid = 4'b1110; req_ok = 1'b1; end
      default: ;
    endcase
    if (req_data && (32'(bus.buffer_occupancy) > MAX_PAYLOAD)) req_ok = 1'b0;
  end

  // Next-state logic. Every field advances only on a bit-time boundary; the
  // stuff check runs before normal advance so owed stuff bits precede EOP.
  always_comb begin
    state_n      = state;
    tmr_n        = tmr;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    pid_byte_n   = pid_byte;
    nxt_n        = get_d ? bus.tx_packet_data : nxt;
    crc_n        = crc;
    bytes_left_n = bytes_left;
    ones_n       = ones;
    stuffing_n   = stuffing;
    line_k_n     = line_k;
    se0_cnt_n    = se0_cnt;
    is_data_n    = is_data;
    have_next_n  = have_next;
    abort_n      = abort;
    get_n        = 1'b0;
    err_n        = 1'b0;
    emit_en      = 1'b0;
    emit_bit     = 1'b0;
    load_en      = 1'b0;
    load_byte    = '0;
    fetch_req    = 1'b0;

    if (state == S_IDLE) begin
      if (bus.tx_start) begin
        if (req_ok) begin
          state_n      = S_SYNC;
          tmr_n        = '0;
          bit_idx_n    = '0;
          pid_byte_n   = {~req_pid, req_pid};
          crc_n        = 16'hFFFF;
          bytes_left_n = req_data ? bus.buffer_occupancy : '0;
          is_data_n    = req_data;
          have_next_n  = 1'b0;
          abort_n      = 1'b0;
          stuffing_n   = 1'b0;
          shreg_n      = SYNC_BYTE;
          emit_en      = 1'b1;
          emit_bit     = SYNC_BYTE[0];
        end else begin
          err_n = 1'b1;
        end
      end
    end else begin
      tmr_n = (tmr == TMR_LAST) ? '0 : tmr + TW'(1);
      if (tmr == TMR_LAST) begin
        unique case (state)
          S_EOP_SE0: begin
            if (se0_cnt) begin
              state_n  = S_EOP_J;
              line_k_n = 1'b0;
            end else begin
              se0_cnt_n = 1'b1;
            end
          end
          S_EOP_J: begin
            state_n = S_IDLE;
          end
          default: begin
            if (state != S_SYNC && !stuffing && ones == 3'd6) begin
              stuffing_n = 1'b1;
              emit_en    = 1'b1;
              emit_bit   = 1'b0;
            end else begin
              stuffing_n = 1'b0;
              if (bit_idx != 3'd7) begin
                bit_idx_n = bit_idx + 3'd1;
                emit_en   = 1'b1;
                emit_bit  = shreg[bit_idx_n];
                if (bit_idx_n == 3'd7 && !abort && bytes_left != '0 &&
                    (state == S_PAYLOAD || (state == S_PID && is_data)))
                  fetch_req = 1'b1;
              end else begin
                bit_idx_n = '0;
                unique case (state)
                  S_SYNC: begin
                    state_n   = S_PID;
                    load_en   = 1'b1;
                    load_byte = pid_byte;
                  end
                  S_PID, S_PAYLOAD: begin
                    if (!is_data || abort) begin
                      state_n   = S_EOP_SE0;
                      se0_cnt_n = 1'b0;
                    end else if (have_next) begin
                      state_n     = S_PAYLOAD;
                      load_en     = 1'b1;
                      load_byte   = nxt;
                      crc_n       = crc16_byte(crc, nxt);
                      have_next_n = 1'b0;
                    end else begin
                      state_n   = S_CRC_LO;
                      load_en   = 1'b1;
                      load_byte = ~crc[7:0];
                    end
                  end
                  S_CRC_LO: begin
                    state_n   = S_CRC_HI;
                    load_en   = 1'b1;
                    load_byte = ~crc[15:8];
                  end
                  default: begin
                    state_n   = S_EOP_SE0;
                    se0_cnt_n = 1'b0;
                  end
                endcase
              end
            end
          end
        endcase
      end
    end

    if (fetch_req) begin
`ifdef USB_TX_UNDERRUN_CHECK_EN
      if (bus.buffer_occupancy == '0) begin
        abort_n = 1'b1;
        err_n   = 1'b1;
      end else begin
        get_n        = 1'b1;
        bytes_left_n = bytes_left - 7'd1;
        have_next_n  = 1'b1;
      end
`else
      get_n        = 1'b1;
      bytes_left_n = bytes_left - 7'd1;
      have_next_n  = 1'b1;
`endif
    end

    if (load_en) begin
      shreg_n  = load_byte;
      emit_en  = 1'b1;
      emit_bit = load_byte[0];
    end

    // NRZI: a 0 toggles the line, a 1 holds it; runs of 1s feed the stuffer.
    if (emit_en) begin
      line_k_n = emit_bit ? line_k : ~line_k;
      ones_n   = emit_bit ? ones + 3'd1 : '0;
    end
  end

  // State and datapath registers; reset parks the line at J in IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      tmr        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      pid_byte   <= '0;
      nxt        <= '0;
      crc        <= '1;
      bytes_left <= '0;
      ones       <= '0;
      stuffing   <= 1'b0;
      line_k     <= 1'b0;
      se0_cnt    <= 1'b0;
      is_data    <= 1'b0;
      have_next  <= 1'b0;
      abort      <= 1'b0;
      get_q      <= 1'b0;
      get_d      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      tmr        <= tmr_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      pid_byte   <= pid_byte_n;
      nxt        <= nxt_n;
      crc        <= crc_n;
      bytes_left <= bytes_left_n;
      ones       <= ones_n;
      stuffing   <= stuffing_n;
      line_k     <= line_k_n;
      se0_cnt    <= se0_cnt_n;
      is_data    <= is_data_n;
      have_next  <= have_next_n;
      abort      <= abort_n;
      get_q      <= get_n;
      get_d      <= get_q;
      err_q      <= err_n;
    end
  end

  assign bus.get_tx_packet_data = get_q;
  assign bus.tx_transfer_active = (state != S_IDLE);
  assign bus.tx_error           = err_q;
  assign dplus_out              = (state == S_EOP_SE0) ? 1'b0 : ~line_k;
  assign dminus_out             = (state == S_EOP_SE0) ? 1'b0 : line_k;

endmodule
